// File: rtl/seq_pkg.sv
// seq_pkg: types and reset values shared by the serial sequence-detector family
// and its upstream feeders.
//   state_t       : shifter state encoding (ST_IDLE, ST_SHIFT)
//   RST_A         : reset value of the serial bit line
//   RST_A_VALID   : reset value of the serial bit qualifier
//   RST_WORD_DONE : reset value of the end-of-word pulse
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic RST_A         = 1'b0;
    localparam logic RST_A_VALID   = 1'b0;
    localparam logic RST_WORD_DONE = 1'b0;

endpackage

// File: rtl/seq_word_fifo.sv
// seq_word_fifo: synchronous word FIFO with registered occupancy count.
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, empties the FIFO
//   push     in   write wr_data at the tail (ignored when full)
//   wr_data  in   WIDTH-bit word to write
//   pop      in   advance the head (ignored when empty)
//   rd_data  out  word at the head (valid when not empty)
//   full     out  DEPTH words stored
//   empty    out  no words stored
//   count    out  occupancy, $clog2(DEPTH+1) bits
module seq_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, so a same-cycle pop never
    // opens room for a push into a full FIFO.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer increments wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: buffers parallel words and shifts them out one bit per
// clock with no bubble between consecutive words.
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_data    in   WIDTH-bit word to serialize
//   in_valid   in   in_data valid
//   in_ready   out  FIFO not full (from registered count)
//   a          out  serial bit (registered), 0 when idle
//   a_valid    out  a carries a data bit (registered)
//   word_done  out  high during the last bit of each word
//   busy       out  shifter active or FIFO non-empty
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             a,
    output logic             a_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int CNTW = $clog2(WIDTH);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             a_valid_q, a_valid_d;

    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             reload;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    seq_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign a         = a_q;
    assign a_valid   = a_valid_q;
    // cnt_q reaches 0 exactly while the last bit of a word is on a.
    assign word_done = a_valid_q && (cnt_q == '0);
    assign busy      = (state_q == ST_SHIFT) || (fifo_count != '0);

    // A new word is loaded either from idle or on the last bit of the
    // current word, which keeps back-to-back words contiguous.
    assign reload = !fifo_empty && ((state_q == ST_IDLE) || (cnt_q == '0));

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        a_d       = 1'b0;
        a_valid_d = 1'b0;
        fifo_pop  = 1'b0;
        if (reload) begin
            // The first bit goes straight to the output register; sr keeps
            // the remaining bits.
            fifo_pop  = 1'b1;
            a_d       = first_bit(fifo_rd_data);
            a_valid_d = 1'b1;
            sr_d      = shift_word(fifo_rd_data);
            cnt_d     = LAST_IDX;
            state_d   = ST_SHIFT;
        end else if (state_q == ST_SHIFT) begin
            if (cnt_q != '0) begin
                a_d       = first_bit(sr_q);
                a_valid_d = 1'b1;
                sr_d      = shift_word(sr_q);
                cnt_d     = cnt_q - 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            a_q       <= RST_A;
            a_valid_q <= RST_A_VALID;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            a_valid_q <= a_valid_d;
        end
    end

endmodule
